// File: rtl/fft_unloader.sv
// fft_unloader: captures a bit-reversed parallel FFT frame and
// streams bins in natural order over valid/ready, with a pending slot.
module fft_unloader #(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 16,
    localparam int BIN_W     = (N > 1) ? $clog2(N) : 1
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic [DATA_WIDTH*2*N-1:0]    cplx_data_in,
    input  logic                         en,
    input  logic                         out_ready,
    output logic [2*DATA_WIDTH-1:0]      out_data,
    output logic [BIN_W-1:0]             out_bin,
    output logic                         out_valid,
    output logic                         out_last,
    output logic                         overflow
);

    localparam int SW = 2 * DATA_WIDTH;
    localparam int FW = SW * N;
    localparam logic [BIN_W-1:0] LAST = BIN_W'(N - 1);

    logic [FW-1:0]    active;
    logic [FW-1:0]    pending;
    logic             act_v;
    logic             pend_v;
    logic [BIN_W-1:0] cnt;
    logic [BIN_W-1:0] rev;
    logic [SW-1:0]    lane_sel;
    logic             fire;
    logic             rel;

    function automatic logic [BIN_W-1:0] bitrev(input logic [BIN_W-1:0] v);
        logic [BIN_W-1:0] r;
        for (int i = 0; i < BIN_W; i++) begin
            r[i] = v[BIN_W-1-i];
        end
        return r;
    endfunction

    assign fire = act_v && out_ready;
    assign rel  = fire && (cnt == LAST);
    assign rev  = (N > 1) ? bitrev(cnt) : '0;

    // Select the lane holding natural-order bin cnt (lane 0 is the MSB lane).
    always_comb begin
        lane_sel = '0;
        for (int s = 0; s < N; s++) begin
            if (BIN_W'(s) == rev) begin
                lane_sel = active[(N-1-s)*SW +: SW];
            end
        end
    end

    assign out_valid = act_v;
    assign out_data  = lane_sel;
    assign out_bin   = cnt;
    assign out_last  = act_v && (cnt == LAST);

    // Slot occupancy, frame loading, bin counter and overrun pulse.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            active   <= '0;
            pending  <= '0;
            act_v    <= 1'b0;
            pend_v   <= 1'b0;
            cnt      <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= 1'b0;
            if (fire) begin
                cnt <= rel ? '0 : cnt + BIN_W'(1);
            end
            if (!act_v || (rel && !pend_v)) begin
                act_v <= en;
                if (en) active <= cplx_data_in;
            end else if (rel) begin
                active <= pending;
                pend_v <= en;
                if (en) pending <= cplx_data_in;
            end else if (!pend_v) begin
                if (en) begin
                    pend_v  <= 1'b1;
                    pending <= cplx_data_in;
                end
            end else begin
                overflow <= en;
            end
        end
    end

endmodule

// File: tb/tb_fft_unloader.sv
// tb_fft_unloader: directed tests for the FFT output reorder unit.
// Covers reset, ordering, backpressure, back-to-back, overflow, N=1.
module tb_fft_unloader;

    logic         clk = 1'b0;
    logic         n_rst;
    logic [255:0] din;
    logic         en;
    logic         out_ready;
    logic [31:0]  out_data;
    logic [2:0]   out_bin;
    logic         out_valid;
    logic         out_last;
    logic         overflow;

    logic [31:0]  din1;
    logic         en1;
    logic [31:0]  out_data1;
    logic [0:0]   out_bin1;
    logic         out_valid1;
    logic         out_last1;
    logic         overflow1;

    int total = 0;
    int bad   = 0;
    int rev [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    fft_unloader #(.N(8), .DATA_WIDTH(16)) dut (
        .clk(clk), .n_rst(n_rst), .cplx_data_in(din), .en(en),
        .out_ready(out_ready), .out_data(out_data), .out_bin(out_bin),
        .out_valid(out_valid), .out_last(out_last), .overflow(overflow)
    );

    fft_unloader #(.N(1), .DATA_WIDTH(16)) dut1 (
        .clk(clk), .n_rst(n_rst), .cplx_data_in(din1), .en(en1),
        .out_ready(out_ready), .out_data(out_data1), .out_bin(out_bin1),
        .out_valid(out_valid1), .out_last(out_last1), .overflow(overflow1)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] mk(input int br, input int bi);
        logic [255:0] f;
        for (int s = 0; s < 8; s++) begin
            f[(7-s)*32 +: 32] = {16'(br + s), 16'(bi + s)};
        end
        return f;
    endfunction

    function automatic logic [36:0] ex(input int br, input int bi, input int b);
        return {1'b1, b == 7, 3'(b), 16'(br + rev[b]), 16'(bi + rev[b])};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        n_rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            din = {8{$urandom()}};
            en = 1'($urandom());
            out_ready = 1'($urandom());
            step();
            total++;
            if ({out_valid, out_last, out_bin, out_data, overflow} !== 38'd0) begin
                bad++;
                $display("FAIL reset_outs got=%h want=0",
                    {out_valid, out_last, out_bin, out_data, overflow});
            end
        end
        en = 1'b0;
        en1 = 1'b0;
        n_rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL reset_idle got=%b want=0", out_valid);
            end
        end
    endtask

    task automatic test_single;
        din = mk(0, 100);
        en = 1'b1;
        out_ready = 1'b1;
        step();
        en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            total++;
            if ({out_valid, out_last, out_bin, out_data} !== ex(0, 100, i)) begin
                bad++;
                $display("FAIL single_bin%0d got=%h want=%h", i,
                    {out_valid, out_last, out_bin, out_data}, ex(0, 100, i));
            end
            step();
        end
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_after got=%b want=0", out_valid);
        end
    endtask

    task automatic test_backpressure;
        int vc;
        vc = 0;
        din = mk(0, 100);
        en = 1'b1;
        out_ready = 1'b1;
        step();
        en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) vc++;
            total++;
            if ({out_valid, out_last, out_bin, out_data} !== ex(0, 100, i)) begin
                bad++;
                $display("FAIL bp_bin%0d got=%h want=%h", i,
                    {out_valid, out_last, out_bin, out_data}, ex(0, 100, i));
            end
            if (i == 2) begin
                out_ready = 1'b0;
                for (int h = 0; h < 3; h++) begin
                    step();
                    if (out_valid) vc++;
                    total++;
                    if ({out_valid, out_last, out_bin, out_data} !== ex(0, 100, 2)) begin
                        bad++;
                        $display("FAIL bp_hold%0d got=%h want=%h", h,
                            {out_valid, out_last, out_bin, out_data}, ex(0, 100, 2));
                    end
                end
                out_ready = 1'b1;
            end
            step();
        end
        if (out_valid) vc++;
        total++;
        if (vc !== 11) begin
            bad++;
            $display("FAIL bp_count got=%0d want=11", vc);
        end
    endtask

    task automatic test_back_to_back;
        int ov;
        ov = 0;
        din = mk(0, 100);
        en = 1'b1;
        out_ready = 1'b1;
        step();
        for (int i = 0; i < 16; i++) begin
            if (overflow) ov++;
            total++;
            if (i < 8 && {out_valid, out_last, out_bin, out_data} !== ex(0, 100, i)) begin
                bad++;
                $display("FAIL b2b_A%0d got=%h want=%h", i,
                    {out_valid, out_last, out_bin, out_data}, ex(0, 100, i));
            end else if (i >= 8 &&
                         {out_valid, out_last, out_bin, out_data} !== ex(16, 200, i - 8)) begin
                bad++;
                $display("FAIL b2b_B%0d got=%h want=%h", i - 8,
                    {out_valid, out_last, out_bin, out_data}, ex(16, 200, i - 8));
            end
            if (i == 0) begin
                din = mk(16, 200);
                en = 1'b1;
            end else begin
                en = 1'b0;
            end
            step();
        end
        total++;
        if ({out_valid, ov[0]} !== 2'b00 || ov !== 0) begin
            bad++;
            $display("FAIL b2b_end got valid=%b ov=%0d want 0 0", out_valid, ov);
        end
    endtask

    task automatic test_overflow;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            din = mk(32 * k, 64 * k + 1);
            en = 1'b1;
            step();
            total++;
            if (overflow !== (k == 2)) begin
                bad++;
                $display("FAIL ovf_pulse%0d got=%b want=%b", k, overflow, k == 2);
            end
        end
        en = 1'b0;
        step();
        total++;
        if (overflow !== 1'b0) begin
            bad++;
            $display("FAIL ovf_clear got=%b want=0", overflow);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            total++;
            if (i < 8 && {out_valid, out_last, out_bin, out_data} !== ex(0, 1, i)) begin
                bad++;
                $display("FAIL ovf_A%0d got=%h want=%h", i,
                    {out_valid, out_last, out_bin, out_data}, ex(0, 1, i));
            end else if (i >= 8 &&
                         {out_valid, out_last, out_bin, out_data} !== ex(32, 65, i - 8)) begin
                bad++;
                $display("FAIL ovf_B%0d got=%h want=%h", i - 8,
                    {out_valid, out_last, out_bin, out_data}, ex(32, 65, i - 8));
            end
            step();
        end
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL ovf_noC got=%b want=0", out_valid);
        end
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b1;
        din = mk(0, 100);
        en = 1'b1;
        step();
        din = mk(16, 200);
        step();
        en = 1'b0;
        step();
        step();
        total++;
        if ({out_valid, out_bin} !== 4'b1011) begin
            bad++;
            $display("FAIL mid_pre got=%b want=1011", {out_valid, out_bin});
        end
        n_rst = 1'b0;
        #1;
        total++;
        if ({out_valid, out_last, out_bin, out_data} !== 37'd0) begin
            bad++;
            $display("FAIL mid_async got=%h want=0",
                {out_valid, out_last, out_bin, out_data});
        end
        step();
        n_rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL mid_residual%0d got=%b want=0", k, out_valid);
            end
        end
        din = mk(48, 300);
        en = 1'b1;
        step();
        en = 1'b0;
        total++;
        if ({out_valid, out_last, out_bin, out_data} !== ex(48, 300, 0)) begin
            bad++;
            $display("FAIL mid_restart got=%h want=%h",
                {out_valid, out_last, out_bin, out_data}, ex(48, 300, 0));
        end
        repeat (8) step();
    endtask

    task automatic test_n1;
        out_ready = 1'b1;
        din1 = 32'h1234_abcd;
        en1 = 1'b1;
        step();
        din1 = 32'h8765_0042;
        total++;
        if ({out_valid1, out_last1, out_bin1, out_data1} !== {3'b110, 32'h1234_abcd}) begin
            bad++;
            $display("FAIL n1_first got=%h want=%h",
                {out_valid1, out_last1, out_bin1, out_data1}, {3'b110, 32'h1234_abcd});
        end
        step();
        en1 = 1'b0;
        total++;
        if ({out_valid1, out_last1, out_bin1, out_data1, overflow1} !==
            {3'b110, 32'h8765_0042, 1'b0}) begin
            bad++;
            $display("FAIL n1_second got=%h want=%h",
                {out_valid1, out_last1, out_bin1, out_data1, overflow1},
                {3'b110, 32'h8765_0042, 1'b0});
        end
        step();
        total++;
        if ({out_valid1, out_last1} !== 2'b00) begin
            bad++;
            $display("FAIL n1_idle got=%b want=00", {out_valid1, out_last1});
        end
    endtask

    initial begin
        n_rst = 1'b0;
        din = '0;
        en = 1'b0;
        din1 = '0;
        en1 = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        test_n1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fft_unloader.md
# fft_unloader

Output reorder and serialiser for the recursive FFT. Captures one parallel frame of N complex bins on the FFT's `en_out` strobe, undoes the bit-reversed lane order, and streams bins 0..N-1 one per handshake on a valid/ready interface. A two-slot frame buffer (active + pending) absorbs back-to-back FFT frames without bubbles, and overruns are flagged.

## Interface
- `N`, 8: FFT size; power of 2, ≥1.
- `DATA_WIDTH`, 16: width of each real and imaginary component (signed, two's complement).
- `BIN_W`: derived, max(1, clog2(N)).

- `clk` input 1: single clock, rising edge.
- `n_rst` input 1: asynchronous, active-low reset.
- `cplx_data_in` input DATA_WIDTH*2*N: parallel FFT frame. Lane s (s=0 is most significant) occupies bits [2W(N-s)-1 : 2W(N-s-1)], formatted {re, im}.
- `en` input 1: one-cycle frame strobe; connects to FFT `en_out`.
- `out_ready` input 1: downstream accepts the current sample.
- `out_data` output 2*DATA_WIDTH: {re, im} of the current bin.
- `out_bin` output BIN_W: natural-order bin index of `out_data`.
- `out_valid` output 1: `out_data` is valid.
- `out_last` output 1: the current bin is N-1.
- `overflow` output 1: one-cycle pulse when an incoming frame is dropped.

## Operation
- Mapping: lane s holds bin bitrev(s) over BIN_W bits. Output bin b is read from lane bitrev(b). For N=1, this is the identity mapping and `out_last` is high whenever `out_valid` is high.
- Storage: `active` and `pending` frame registers, each with an occupied flag. A bin counter `cnt` (BIN_W bits) indexes `active`.
- Handshake: a transfer occurs when `out_valid && out_ready`. Each transfer increments `cnt`. The transfer at `cnt`=N-1 releases `active` and resets `cnt` to 0.
- While `out_valid=1 && out_ready=0`, `out_data`, `out_bin` and `out_last` hold stable.
- `out_valid` = `active` occupied. `out_data` = `active` lane bitrev(`cnt`). `out_bin` = `cnt`. `out_last` = `out_valid && cnt==N-1`.
- Frame load priority, evaluated per cycle, with release meaning the final transfer of `active` happens this cycle:
  - `active` empty, or released with `pending` empty: `en` loads `active`.
  - `active` occupied and not released, `pending` empty: `en` loads `pending`.
  - `active` released with `pending` full: `pending` moves to `active`. `en`, if present, loads `pending`. No overflow.
  - Both full, no release: `en` is dropped and `overflow` pulses the next cycle.
- When `active` is released with `pending` full and no `en`, `pending` moves to `active` and `pending` becomes empty.
- No arithmetic is performed. Data passes through bit-exact.

## Timing
- Reset values: `out_valid`=0, `out_last`=0, `out_data`=0, `out_bin`=0, `overflow`=0. Both slots are empty and `cnt`=0.
- Reset asserted mid-stream discards both slots immediately; outputs take reset values asynchronously.
- Latency: `en` at edge t into an empty unit makes bin 0 valid after edge t+1 (registered).
- With `out_ready` held high, bins stream one per cycle. A frame occupies exactly N cycles.
- Back-to-back frames (`en` every N cycles, or faster while `pending` is free) stream with zero idle cycles between `out_last` and the next bin 0.
- `overflow` is a registered pulse, one cycle after the dropped `en`.
- `en` is sampled only on rising edges. `cplx_data_in` is captured on the same edge as `en`.

## Test plan
- Reset: hold `n_rst` low with random inputs. Required: all outputs 0. Release reset with `en`=0 for 5 cycles. Required: `out_valid` stays 0.
- Single frame, N=8, W=16. Load lane s with {re=s, im=100+s}, pulse `en`, `out_ready`=1. Required over 8 consecutive cycles starting after the next edge:
  - re = 0,4,2,6,1,5,3,7
  - im = 100 + the same lane index
  - `out_bin` = 0..7
  - `out_last` high only on the 8th cycle, `out_valid` low afterwards.
- Backpressure: as above, with `out_ready` low while `out_bin`=2 for 3 cycles. Required: re=2 held stable for 4 cycles. The sequence completes unchanged after 11 valid cycles total.
- Back-to-back: `en` on two consecutive cycles with frames A and B, `out_ready`=1. Required:
  - 16 contiguous valid cycles, A then B.
  - `out_last` on cycles 8 and 16.
  - `overflow` never asserted.
- Overflow: `out_ready`=0, then three `en` pulses carrying frames A, B, C. Required: a single `overflow` pulse one cycle after the third `en`. Releasing `out_ready` streams A then B only.
- Reset mid-stream: assert `n_rst` after 3 transfers of a frame while `pending` is full. Required: immediate `out_valid`=0. After release, no residual data is output until a new `en` arrives, which starts at `out_bin`=0.
